// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline constants for register-address handling.
// Also used by the forwarding unit.
package hazard_detection_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detection_unit_reg_match.sv
// Register-address compare with x0 exclusion.
// The match is gated by an enable, such as "EX holds a load".
import hazard_detection_unit_pkg::*;

module hazard_detection_unit_reg_match (
    input  logic                  i_en,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [REG_ADDR_W-1:0] i_rs,
    output logic                  o_match
);

    assign o_match = i_en && (i_rd != REG_ZERO) && (i_rd == i_rs);

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector.
// Decides stalls combinationally and keeps registered stall status and a saturating stall counter.
import hazard_detection_unit_pkg::*;

module hazard_detection_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs2,
    input  logic                  ID_EX_MEMRead,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_MuxSelect,
    output logic                  hazard_rs1,
    output logic                  hazard_rs2,
    output logic                  stall_q,
    output logic [CNT_W-1:0]      stall_count
);

    logic             w_hazard_rs1;
    logic             w_hazard_rs2;
    logic             w_stall;
    logic             w_cnt_sat;
    logic             r_stall;
    logic [CNT_W-1:0] r_stall_count;

    hazard_detection_unit_reg_match u_match_rs1 (
        .i_en    (ID_EX_MEMRead),
        .i_rd    (ID_EX_RegisterRd),
        .i_rs    (IF_ID_RegisterRs1),
        .o_match (w_hazard_rs1)
    );

    hazard_detection_unit_reg_match u_match_rs2 (
        .i_en    (ID_EX_MEMRead),
        .i_rd    (ID_EX_RegisterRd),
        .i_rs    (IF_ID_RegisterRs2),
        .o_match (w_hazard_rs2)
    );

    // A double match still yields a single one-cycle stall.
    assign w_stall   = w_hazard_rs1 | w_hazard_rs2;
    assign w_cnt_sat = &r_stall_count;

    always_comb begin
        PCWrite         = ~w_stall;
        IF_ID_Write     = ~w_stall;
        ID_EX_MuxSelect = w_stall;
        hazard_rs1      = w_hazard_rs1;
        hazard_rs2      = w_hazard_rs2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall       <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_stall <= w_stall;
            if (w_stall && !w_cnt_sat) begin
                r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall_q     = r_stall;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed and randomized checks of hazard_detection_unit against a behavioural model.
// A narrow counter is used so that saturation can be reached.
module tb_hazard_detection_unit;

    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    rd = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic          mr = 1'b0;
    logic          pc_write;
    logic          if_id_write;
    logic          mux_sel;
    logic          h_rs1;
    logic          h_rs2;
    logic          stall_q;
    logic [CW-1:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural reference state
    int m_count = 0;
    bit m_stall_q = 1'b0;

    hazard_detection_unit #(.CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .ID_EX_RegisterRd  (rd),
        .IF_ID_RegisterRs1 (rs1),
        .IF_ID_RegisterRs2 (rs2),
        .ID_EX_MEMRead     (mr),
        .PCWrite           (pc_write),
        .IF_ID_Write       (if_id_write),
        .ID_EX_MuxSelect   (mux_sel),
        .hazard_rs1        (h_rs1),
        .hazard_rs2        (h_rs2),
        .stall_q           (stall_q),
        .stall_count       (stall_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_h1();
        return mr && (rd != 0) && (rd == rs1);
    endfunction

    function automatic bit m_h2();
        return mr && (rd != 0) && (rd == rs2);
    endfunction

    function automatic bit m_stall();
        return m_h1() || m_h2();
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_count   <= 0;
            m_stall_q <= 1'b0;
        end else begin
            m_stall_q <= m_stall();
            if (m_stall()) m_count <= (m_count < int'(CMAX)) ? m_count + 1 : int'(CMAX);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/pcwrite"}, 32'(pc_write), 32'(!m_stall()));
        chk({tag, "/ifid"}, 32'(if_id_write), 32'(!m_stall()));
        chk({tag, "/mux"}, 32'(mux_sel), 32'(m_stall()));
        chk({tag, "/h1"}, 32'(h_rs1), 32'(m_h1()));
        chk({tag, "/h2"}, 32'(h_rs2), 32'(m_h2()));
        chk({tag, "/stall_q"}, 32'(stall_q), 32'(m_stall_q));
        chk({tag, "/count"}, 32'(stall_count), 32'(m_count));
    endtask

    task automatic drive(input int a_rd, input int a_rs1, input int a_rs2, input int a_mr);
        @(negedge clk);
        rd  = 5'(a_rd);
        rs1 = 5'(a_rs1);
        rs2 = 5'(a_rs2);
        mr  = 1'(a_mr);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("reset/stall_q", 32'(stall_q), 32'd0);
        chk("reset/count", 32'(stall_count), 32'd0);
        chk("zero/pcwrite", 32'(pc_write), 32'd1);
        chk("zero/ifid", 32'(if_id_write), 32'd1);
        chk("zero/mux", 32'(mux_sel), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        drive(2, 3, 4, 0);
        chk_all("nomr");
        chk("nomr/mux_const", 32'(mux_sel), 32'd0);

        drive(2, 2, 4, 1);
        chk_all("rs1hit");
        chk("rs1hit/pc_const", 32'(pc_write), 32'd0);
        chk("rs1hit/h1_const", 32'(h_rs1), 32'd1);
        @(posedge clk);
        #1;
        chk("rs1hit/stall_q_const", 32'(stall_q), 32'd1);
        chk("rs1hit/count_const", 32'(stall_count), 32'd1);

        drive(3, 5, 3, 1);
        chk_all("rs2hit");
        chk("rs2hit/h2_const", 32'(h_rs2), 32'd1);
        chk("rs2hit/mux_const", 32'(mux_sel), 32'd1);

        drive(8, 12, 13, 1);
        chk_all("nomatch");
        drive(1, 1, 2, 0);
        chk_all("match_noload");
        chk("match_noload/mux_const", 32'(mux_sel), 32'd0);
        drive(0, 0, 0, 1);
        chk_all("x0load");
        chk("x0load/pc_const", 32'(pc_write), 32'd1);
        drive(7, 7, 7, 1);
        chk_all("bothhit");

        // Hold a stall, then pulse reset between edges
        for (int i = 0; i < 4; i++) begin
            drive(9, 9, 1, 1);
            chk_all("hold");
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset/stall_q", 32'(stall_q), 32'd0);
        chk("midreset/count", 32'(stall_count), 32'd0);
        chk("midreset/mux", 32'(mux_sel), 32'd1);
        chk("midreset/pcwrite", 32'(pc_write), 32'd0);
        #1 reset = 1'b0;

        // Drive the counter into saturation
        for (int i = 0; i < int'(CMAX) + 6; i++) begin
            drive(4, 1, 4, 1);
            chk_all("sat");
        end
        chk("sat/count_const", 32'(stall_count), 32'(CMAX));

        // Randomized sweep with biased matches; reset occasionally to reuse the counter range
        for (int i = 0; i < 400; i++) begin
            int r_rd;
            int r_rs1;
            int r_rs2;
            int r_mr;
            r_rd  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31));
            r_rs1 = ($urandom_range(0, 2) == 0) ? r_rd : int'($urandom_range(0, 31));
            r_rs2 = ($urandom_range(0, 2) == 0) ? r_rd : int'($urandom_range(0, 31));
            r_mr  = int'($urandom_range(0, 1));
            drive(r_rd, r_rs1, r_rs2, r_mr);
            chk_all("rand");
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                #1;
                chk("rand/reset_count", 32'(stall_count), 32'd0);
                reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Load-use hazard detector for the five-stage pipelined RISC-V core, sitting between the IF/ID and ID/EX pipeline registers. When the instruction in EX is a load whose destination matches a source register of the instruction in ID, it freezes PC and IF/ID for one cycle and steers a bubble into ID/EX. Stall decisions are purely combinational. A small clocked block keeps stall status and statistics for debug and performance counters.

## Interface
Parameters:
- CNT_W, default 32: width of the stall statistics counter.

Ports:
- clk  in  1  core clock; only the status/statistics registers use it.
- reset  in  1  asynchronous, active-high; clears all registered state.
- ID_EX_RegisterRd  in  5  destination register of the instruction in EX.
- IF_ID_RegisterRs1  in  5  rs1 of the instruction in ID.
- IF_ID_RegisterRs2  in  5  rs2 of the instruction in ID.
- ID_EX_MEMRead  in  1  instruction in EX is a load.
- PCWrite  out  1  1 = PC updates; 0 = hold PC.
- IF_ID_Write  out  1  1 = IF/ID loads; 0 = hold IF/ID.
- ID_EX_MuxSelect  out  1  1 = zero all control signals entering ID/EX (bubble); 0 = pass decoded controls.
- hazard_rs1  out  1  combinational: rs1 load-use match.
- hazard_rs2  out  1  combinational: rs2 load-use match.
- stall_q  out  1  registered: a stall was asserted in the previous cycle.
- stall_count  out  CNT_W  registered: number of stall cycles since reset.

## Operation
- hazard_rs1 = ID_EX_MEMRead & (ID_EX_RegisterRd != 0) & (ID_EX_RegisterRd == IF_ID_RegisterRs1).
- hazard_rs2 is the same check against IF_ID_RegisterRs2.
- stall = hazard_rs1 | hazard_rs2.
- PCWrite = ~stall, IF_ID_Write = ~stall, ID_EX_MuxSelect = stall.
- x0 is never a hazard. A load to x0 does not stall.
- With ID_EX_MEMRead = 0 there is never a stall, even if the registers match.
- Both sources matching gives a single stall, the same as one match.
- Outputs must never be X or Z while all inputs are known.

## Timing
- PCWrite, IF_ID_Write, ID_EX_MuxSelect, hazard_rs1 and hazard_rs2 are combinational, with zero-cycle latency from the inputs.
- These combinational outputs do not depend on clk or reset; reset does not force them.
- stall_q: on each rising clk edge it loads stall. Its reset value is 0.
- stall_count: on each rising clk edge it increments when stall = 1 and saturates at all-ones (no wrap). Its reset value is 0.
- Reset asserted mid-stall: stall_q and stall_count clear immediately (asynchronous). The combinational outputs keep tracking the inputs.
- One load-use event yields exactly one stall cycle, because next cycle the load has moved on to MEM.
- Removing the stall on the following cycle is the job of the pipeline registers, not this block.

## Structure
- Shared pipeline package holds REG_ADDR_W = 5 and the x0 index constant REG_ZERO = 5'd0. The core's forwarding unit reuses both.
- One natural sub-module, reg_match: a 5-bit compare with x0 exclusion and an enable input. Instantiate it twice, once for rs1 and once for rs2.
- The rest is the top-level combinational glue plus the status/counter flops.

## Test plan
- All inputs 0 -> PCWrite=1, IF_ID_Write=1, ID_EX_MuxSelect=0.
- Rd=2, Rs1=3, Rs2=4, MEMRead=0 -> no stall (1,1,0).
- Rd=2, Rs1=2, Rs2=4, MEMRead=1 -> stall (0,0,1) with hazard_rs1=1. Next clk edge: stall_q=1, stall_count=1.
- Rd=3, Rs1=5, Rs2=3, MEMRead=1 -> stall (0,0,1) with hazard_rs2=1.
- Rd=8, Rs1=12, Rs2=13, MEMRead=1 -> no stall. Rd=1, Rs1=1, Rs2=2, MEMRead=0 -> no stall. Rd=0, Rs1=0, MEMRead=1 -> no stall.
- Hold a stall for several cycles, then pulse reset between clock edges -> stall_q and stall_count read 0 immediately. Separately, preload the counter to all-ones and stall -> it stays all-ones.
